// File: rtl/wb_xbar_rr.sv
// Wishbone classic shared-bus interconnect: NM masters, NS slaves, one transfer
// at a time. A round-robin arbiter picks a master, the top address bits select a
// slave, and unmapped addresses or a slave that never acks end in a one-cycle
// error pulse back to the master.
module wb_xbar_rr #(
    parameter int NM = 2,
    parameter int NS = 8,
    parameter int SB = 3,
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int TO = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*(DW/8)-1:0] m_sel_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM-1:0]        m_stb_i,
    output logic [DW-1:0]        m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [(DW/8)-1:0]    s_sel_o,
    output logic                 s_we_o,
    output logic [NS-1:0]        s_stb_o,
    input  logic [NS*DW-1:0]     s_dat_i,
    input  logic [NS-1:0]        s_ack_i,
    output logic [NM-1:0]        gnt_o
);

    localparam int SW = DW / 8;
    localparam int PW = (NM > 1) ? $clog2(NM) : 1;
    localparam int TW = $clog2(TO + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [NM-1:0] gnt, gnt_nxt;
    logic [SB-1:0] sidx, sidx_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [TW-1:0] timer, timer_nxt;

    logic          req_any;
    logic [PW-1:0] req_idx;
    logic [SB-1:0] req_sidx;
    int            arb_cand;

    logic [PW-1:0] gidx;
    logic [PW-1:0] gidx_inc;

    logic [DW-1:0] mst_dat;
    logic [AW-1:0] mst_adr;
    logic [SW-1:0] mst_sel;
    logic          mst_we;
    logic          mst_stb;

    logic [DW-1:0] slave_dat;
    logic          slave_ack;
    logic          timed_out;

    // A slave index is only usable when it names one of the NS mapped slaves.
    function automatic logic is_mapped(input logic [SB-1:0] idx);
        return (32'(idx) < 32'(NS));
    endfunction

    // Round-robin search: first requesting master at or after ptr, wrapping past NM-1.
    always_comb begin
        req_any  = 1'b0;
        req_idx  = '0;
        req_sidx = '0;
        arb_cand = 0;
        for (int i = 0; i < NM; i++) begin
            arb_cand = (int'(ptr) + i) % NM;
            if (!req_any && m_stb_i[arb_cand]) begin
                req_any  = 1'b1;
                req_idx  = PW'(arb_cand);
                req_sidx = m_adr_i[arb_cand*AW + AW - 1 -: SB];
            end
        end
    end

    // Convert the one-hot grant into an index for pointer advancement.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NM; i++) begin
            if (gnt[i]) begin
                gidx = PW'(i);
            end
        end
    end

    assign gidx_inc = (gidx == PW'(NM - 1)) ? '0 : gidx + PW'(1);

    // Mux the granted master's request fields; with no grant everything reads zero.
    always_comb begin
        mst_dat = '0;
        mst_adr = '0;
        mst_sel = '0;
        mst_we  = 1'b0;
        mst_stb = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (gnt[i]) begin
                mst_dat = m_dat_i[i*DW +: DW];
                mst_adr = m_adr_i[i*AW +: AW];
                mst_sel = m_sel_i[i*SW +: SW];
                mst_we  = m_we_i[i];
                mst_stb = m_stb_i[i];
            end
        end
    end

    // Pick the addressed slave's ack and read data; acks from other slaves never get through.
    always_comb begin
        slave_dat = '0;
        slave_ack = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (32'(sidx) == 32'(k)) begin
                slave_dat = s_dat_i[k*DW +: DW];
                slave_ack = s_ack_i[k];
            end
        end
    end

    assign timed_out = (timer == TW'(TO));

    assign s_dat_o = mst_dat;
    assign s_adr_o = mst_adr;
    assign s_sel_o = mst_sel;
    assign s_we_o  = mst_we;
    assign gnt_o   = gnt;

    // Strobe, ack, error and read-data routing; once the watchdog fires the slave strobe is withdrawn.
    always_comb begin
        s_stb_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        if (state == BUSY) begin
            m_dat_o = slave_dat;
            if (!timed_out) begin
                for (int k = 0; k < NS; k++) begin
                    if (32'(sidx) == 32'(k)) begin
                        s_stb_o[k] = mst_stb;
                    end
                end
                m_ack_o = gnt & {NM{slave_ack}};
            end
        end else if (state == ERR) begin
            m_err_o = gnt;
        end
    end

    // Next-state logic: grant in IDLE, watch for ack/abort/timeout in BUSY, single-cycle ERR.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sidx_nxt  = sidx;
        ptr_nxt   = ptr;
        timer_nxt = timer;
        unique case (state)
            IDLE: begin
                timer_nxt = '0;
                if (req_any) begin
                    gnt_nxt   = NM'(1) << req_idx;
                    sidx_nxt  = req_sidx;
                    state_nxt = is_mapped(req_sidx) ? BUSY : ERR;
                end
            end
            BUSY: begin
                if (timed_out) begin
                    state_nxt = ERR;
                end else if (slave_ack) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = gidx_inc;
                    timer_nxt = '0;
                end else if (!mst_stb) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            ERR: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                ptr_nxt   = gidx_inc;
                timer_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                timer_nxt = '0;
            end
        endcase
    end

    // State, grant, slave index, round-robin pointer and watchdog registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            gnt   <= '0;
            sidx  <= '0;
            ptr   <= '0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sidx  <= sidx_nxt;
            ptr   <= ptr_nxt;
            timer <= timer_nxt;
        end
    end

endmodule

// File: tb/tb_wb_xbar_rr.sv
// Directed bench for wb_xbar_rr with 2 masters, 5 mapped slaves and a short
// watchdog, covering single transfers, contention, unmapped decode, timeout,
// abort and asynchronous reset.
module tb_wb_xbar_rr;

    localparam int NM = 2;
    localparam int NS = 5;
    localparam int SB = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;
    localparam int SW = DW / 8;

    logic               clk;
    logic               rst_n;
    logic [NM*DW-1:0]   m_dat_i;
    logic [NM*AW-1:0]   m_adr_i;
    logic [NM*SW-1:0]   m_sel_i;
    logic [NM-1:0]      m_we_i;
    logic [NM-1:0]      m_stb_i;
    logic [DW-1:0]      m_dat_o;
    logic [NM-1:0]      m_ack_o;
    logic [NM-1:0]      m_err_o;
    logic [DW-1:0]      s_dat_o;
    logic [AW-1:0]      s_adr_o;
    logic [SW-1:0]      s_sel_o;
    logic               s_we_o;
    logic [NS-1:0]      s_stb_o;
    logic [NS*DW-1:0]   s_dat_i;
    logic [NS-1:0]      s_ack_i;
    logic [NM-1:0]      gnt_o;

    int errors = 0;
    int checks = 0;

    wb_xbar_rr #(
        .NM(NM), .NS(NS), .SB(SB), .DW(DW), .AW(AW), .TO(TO)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .m_dat_i (m_dat_i),
        .m_adr_i (m_adr_i),
        .m_sel_i (m_sel_i),
        .m_we_i  (m_we_i),
        .m_stb_i (m_stb_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_dat_o (s_dat_o),
        .s_adr_o (s_adr_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .gnt_o   (gnt_o)
    );

    // Free-running bus clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop so a stuck run still ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=no finish required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic applyStimulus(input int m, input logic stb, input logic [AW-1:0] adr,
                                 input logic we, input logic [SW-1:0] sel, input logic [DW-1:0] dat);
        m_stb_i[m]           = stb;
        m_adr_i[m*AW +: AW]  = adr;
        m_we_i[m]            = we;
        m_sel_i[m*SW +: SW]  = sel;
        m_dat_i[m*DW +: DW]  = dat;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        m_dat_i = '0;
        m_adr_i = '0;
        m_sel_i = '0;
        m_we_i  = '0;
        m_stb_i = '0;
        s_dat_i = '0;
        s_ack_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_gnt",   64'(gnt_o),   64'h0);
        checkOutput("rst_sstb",  64'(s_stb_o), 64'h0);
        checkOutput("rst_mack",  64'(m_ack_o), 64'h0);
        checkOutput("rst_merr",  64'(m_err_o), 64'h0);
        checkOutput("rst_swe",   64'(s_we_o),  64'h0);
        checkOutput("rst_mdat",  64'(m_dat_o), 64'h0);

        // Test 1: single read from slave 0, ack on the second BUSY cycle
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 32'h1000_0000, 1'b0, 4'hF, 32'h0);
        #1;
        checkOutput("t1_idle_sstb", 64'(s_stb_o), 64'h0);
        checkOutput("t1_idle_gnt",  64'(gnt_o),   64'h0);
        nextCycle();
        #1;
        checkOutput("t1_b1_sstb", 64'(s_stb_o), 64'h01);
        checkOutput("t1_b1_gnt",  64'(gnt_o),   64'h1);
        checkOutput("t1_b1_sadr", 64'(s_adr_o), 64'h1000_0000);
        checkOutput("t1_b1_mack", 64'(m_ack_o), 64'h0);
        nextCycle();
        s_ack_i = 5'b00001;
        s_dat_i[0*DW +: DW] = 32'hDEAD_BEEF;
        #1;
        checkOutput("t1_b2_sstb", 64'(s_stb_o), 64'h01);
        checkOutput("t1_b2_mack", 64'(m_ack_o), 64'h1);
        checkOutput("t1_b2_mdat", 64'(m_dat_o), 64'hDEAD_BEEF);
        nextCycle();
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        s_ack_i = '0;
        #1;
        checkOutput("t1_end_gnt",  64'(gnt_o),   64'h0);
        checkOutput("t1_end_sstb", 64'(s_stb_o), 64'h0);
        checkOutput("t1_end_mack", 64'(m_ack_o), 64'h0);

        // Test 2: contention; M0 was served last so M1 goes first, then alternation
        applyStimulus(0, 1'b1, 32'h0000_0000, 1'b0, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 32'h2000_0000, 1'b0, 4'hF, 32'h0);
        s_ack_i = 5'b00011;
        #1;
        checkOutput("t2_idle_gnt", 64'(gnt_o), 64'h0);
        nextCycle();
        #1;
        checkOutput("t2_g1_gnt",  64'(gnt_o),   64'h2);
        checkOutput("t2_g1_sstb", 64'(s_stb_o), 64'h02);
        checkOutput("t2_g1_mack", 64'(m_ack_o), 64'h2);
        checkOutput("t2_g1_sadr", 64'(s_adr_o), 64'h2000_0000);
        nextCycle();
        checkOutput("t2_gap1_gnt",  64'(gnt_o),   64'h0);
        checkOutput("t2_gap1_mack", 64'(m_ack_o), 64'h0);
        nextCycle();
        checkOutput("t2_g2_gnt",  64'(gnt_o),   64'h1);
        checkOutput("t2_g2_sstb", 64'(s_stb_o), 64'h01);
        checkOutput("t2_g2_mack", 64'(m_ack_o), 64'h1);
        nextCycle();
        checkOutput("t2_gap2_gnt", 64'(gnt_o), 64'h0);
        nextCycle();
        checkOutput("t2_g3_gnt", 64'(gnt_o), 64'h2);
        // Ack from a slave other than the addressed one must be ignored
        m_stb_i[0] = 1'b0;
        s_ack_i = 5'b00001;
        #1;
        checkOutput("t2_wrongack_mack", 64'(m_ack_o), 64'h0);
        nextCycle();
        s_ack_i = 5'b00010;
        #1;
        checkOutput("t2_hold_gnt",  64'(gnt_o),   64'h2);
        checkOutput("t2_hold_mack", 64'(m_ack_o), 64'h2);
        nextCycle();
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        s_ack_i = '0;
        #1;
        checkOutput("t2_end_gnt", 64'(gnt_o), 64'h0);

        // Test 3: unmapped slave index 6 from M1
        applyStimulus(1, 1'b1, 32'hC000_0000, 1'b0, 4'hF, 32'h0);
        #1;
        checkOutput("t3_idle_merr", 64'(m_err_o), 64'h0);
        nextCycle();
        checkOutput("t3_err_merr", 64'(m_err_o), 64'h2);
        checkOutput("t3_err_sstb", 64'(s_stb_o), 64'h0);
        checkOutput("t3_err_mack", 64'(m_ack_o), 64'h0);
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        nextCycle();
        checkOutput("t3_after_merr", 64'(m_err_o), 64'h0);
        checkOutput("t3_after_gnt",  64'(gnt_o),   64'h0);

        // Test 4: slave 2 never acks; watchdog expires after 4 strobed cycles
        applyStimulus(0, 1'b1, 32'h4000_0000, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput("t4_sstb_high", 64'(s_stb_o), 64'h04);
        end
        nextCycle();
        checkOutput("t4_to_sstb", 64'(s_stb_o), 64'h0);
        checkOutput("t4_to_merr", 64'(m_err_o), 64'h0);
        checkOutput("t4_to_gnt",  64'(gnt_o),   64'h1);
        nextCycle();
        checkOutput("t4_err_merr", 64'(m_err_o), 64'h1);
        checkOutput("t4_err_sstb", 64'(s_stb_o), 64'h0);
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        nextCycle();
        checkOutput("t4_idle_merr", 64'(m_err_o), 64'h0);
        checkOutput("t4_idle_gnt",  64'(gnt_o),   64'h0);
        // Follow-up write to slave 3; pointer is at M1 so the search wraps to M0
        applyStimulus(0, 1'b1, 32'h6000_0010, 1'b1, 4'hC, 32'h1234_5678);
        nextCycle();
        checkOutput("t4_wr_gnt",  64'(gnt_o),   64'h1);
        checkOutput("t4_wr_sstb", 64'(s_stb_o), 64'h08);
        checkOutput("t4_wr_swe",  64'(s_we_o),  64'h1);
        checkOutput("t4_wr_sdat", 64'(s_dat_o), 64'h1234_5678);
        checkOutput("t4_wr_ssel", 64'(s_sel_o), 64'hC);
        s_ack_i = 5'b01000;
        #1;
        checkOutput("t4_wr_mack", 64'(m_ack_o), 64'h1);
        nextCycle();
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        s_ack_i = '0;
        #1;
        checkOutput("t4_wr_end_gnt", 64'(gnt_o), 64'h0);

        // Test 5a: M1 aborts; pointer stays at M1 so M1 wins the next contention
        applyStimulus(1, 1'b1, 32'h2000_0000, 1'b0, 4'hF, 32'h0);
        nextCycle();
        checkOutput("t5_busy_gnt", 64'(gnt_o), 64'h2);
        m_stb_i[1] = 1'b0;
        #1;
        checkOutput("t5_drop_sstb", 64'(s_stb_o), 64'h0);
        nextCycle();
        checkOutput("t5_abort_gnt", 64'(gnt_o), 64'h0);
        applyStimulus(0, 1'b1, 32'h0000_0000, 1'b0, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 32'h2000_0000, 1'b1, 4'hF, 32'h0BAD_F00D);
        s_dat_i[1*DW +: DW] = 32'hCAFE_0001;
        s_ack_i = 5'b00010;
        nextCycle();
        checkOutput("t5_ptr_gnt",  64'(gnt_o),   64'h2);
        checkOutput("t5_pre_mack", 64'(m_ack_o), 64'h2);
        checkOutput("t5_pre_mdat", 64'(m_dat_o), 64'hCAFE_0001);

        // Test 5b: reset asserted mid-BUSY clears everything without a clock edge
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_gnt",  64'(gnt_o),   64'h0);
        checkOutput("t5_rst_sstb", 64'(s_stb_o), 64'h0);
        checkOutput("t5_rst_mack", 64'(m_ack_o), 64'h0);
        checkOutput("t5_rst_merr", 64'(m_err_o), 64'h0);
        checkOutput("t5_rst_swe",  64'(s_we_o),  64'h0);
        checkOutput("t5_rst_mdat", 64'(m_dat_o), 64'h0);
        checkOutput("t5_rst_sadr", 64'(s_adr_o), 64'h0);
        s_ack_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("t5_restart_gnt", 64'(gnt_o), 64'h1);
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
